// File: rtl/tnn_dual_popcount_accum.sv
// tnn_dual_popcount_accum: two-lane ternary positive-match popcount accumulator
// feeding the 3-bit adder/threshold comparator neuron with {a, b, c}.
// Optional saturation flag output enabled by defining TNN_ACC_SAT_FLAG_EN.
module tnn_dual_popcount_accum #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_w,
    input  logic             in_last,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_a,
    output logic [CNT_W-1:0] out_b,
    output logic [CNT_W-1:0] out_c,
    output logic [LEN_W-1:0] out_len
`ifdef TNN_ACC_SAT_FLAG_EN
    ,
    output logic             out_sat
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [LEN_W-1:0] cnt_len;
    logic [CNT_W-1:0] cnt_a_nxt;
    logic [CNT_W-1:0] cnt_b_nxt;
    logic [LEN_W-1:0] cnt_len_nxt;
    logic [CNT_W-1:0] thr_reg;
    logic             accept_c;
    logic             last_accept_c;
    logic             prod0_c;
    logic             prod1_c;
    logic             out_fire_c;

    // Ternary code {nz, sign}: product is +1 when both nonzero with equal signs
    function automatic logic pos_match(input logic [1:0] x, input logic [1:0] w);
        return x[1] & w[1] & (x[0] == w[0]);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and saturating next-count logic
    always_comb begin
        state_nxt     = state;
        cnt_a_nxt     = cnt_a;
        cnt_b_nxt     = cnt_b;
        cnt_len_nxt   = cnt_len;
        accept_c      = in_valid & in_ready;
        last_accept_c = accept_c & in_last;
        out_fire_c    = out_valid & out_ready;
        prod0_c       = pos_match(in_x[1:0], in_w[1:0]);
        prod1_c       = pos_match(in_x[3:2], in_w[3:2]);

        if (accept_c) begin
            if (prod0_c && (cnt_a != CNT_MAX)) cnt_a_nxt = cnt_a + CNT_W'(1);
            if (prod1_c && (cnt_b != CNT_MAX)) cnt_b_nxt = cnt_b + CNT_W'(1);
            if (cnt_len != LEN_MAX)            cnt_len_nxt = cnt_len + LEN_W'(1);
        end

        case (state)
            IDLE, ACCUM: begin
                if (accept_c) state_nxt = in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                if (out_fire_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags, threshold register, accumulators and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            thr_reg   <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            cnt_len   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_len   <= '0;
        end else begin
            in_ready  <= (state_nxt != HOLD);
            out_valid <= (state_nxt == HOLD);
            if (cfg_we) thr_reg <= cfg_thr;
            if (last_accept_c) begin
                // Snapshot uses the pre-write threshold; accumulators restart for the next frame
                out_a   <= cnt_a_nxt;
                out_b   <= cnt_b_nxt;
                out_c   <= thr_reg;
                out_len <= cnt_len_nxt;
                cnt_a   <= '0;
                cnt_b   <= '0;
                cnt_len <= '0;
            end else begin
                cnt_a   <= cnt_a_nxt;
                cnt_b   <= cnt_b_nxt;
                cnt_len <= cnt_len_nxt;
            end
        end
    end

`ifdef TNN_ACC_SAT_FLAG_EN
    logic sat_acc;
    logic sat_hit_c;

    // Any counter sitting at its maximum after an accepted beat marks the frame saturated
    assign sat_hit_c = accept_c & ((cnt_a_nxt == CNT_MAX) | (cnt_b_nxt == CNT_MAX) |
                                   (cnt_len_nxt == LEN_MAX));

    // Saturation tracking across the frame and flag presented with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_acc <= 1'b0;
            out_sat <= 1'b0;
        end else if (last_accept_c) begin
            sat_acc <= 1'b0;
            out_sat <= sat_acc | sat_hit_c;
        end else begin
            sat_acc <= sat_acc | sat_hit_c;
            if (out_fire_c) out_sat <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tnn_dual_popcount_accum.sv
// Self-checking bench for tnn_dual_popcount_accum with a frame-level reference model.
module tb_tnn_dual_popcount_accum;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned LEN_W = 8;
    localparam int CNT_LIM = 7;
    localparam int LEN_LIM = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_x = '0;
    logic [3:0]       in_w = '0;
    logic             in_last = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CNT_W-1:0] cfg_thr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_a;
    logic [CNT_W-1:0] out_b;
    logic [CNT_W-1:0] out_c;
    logic [LEN_W-1:0] out_len;
`ifdef TNN_ACC_SAT_FLAG_EN
    logic             out_sat;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: unbounded frame tallies, threshold shadow and snapshot
    int m_a = 0;
    int m_b = 0;
    int m_n = 0;
    int m_thr = 0;
    int m_c = 0;

    tnn_dual_popcount_accum #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .cfg_we    (cfg_we),
        .cfg_thr   (cfg_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_len   (out_len)
`ifdef TNN_ACC_SAT_FLAG_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int tern(input logic [1:0] c);
        if (!c[1]) return 0;
        return c[0] ? -1 : 1;
    endfunction

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one beat at a falling edge and wait until it is taken
    task automatic send_beat(input logic [3:0] x, input logic [3:0] w, input logic last);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        while (in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("beat_accept_wait", 32'(waitc < 50), 32'd1);
        if (tern(x[1:0]) * tern(w[1:0]) == 1) m_a++;
        if (tern(x[3:2]) * tern(w[3:2]) == 1) m_b++;
        m_n++;
        if (last) m_c = m_thr;
        @(negedge clk);
        if (cfg_we) begin
            m_thr  = int'(cfg_thr);
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic write_thr(input logic [CNT_W-1:0] v);
        cfg_we  = 1'b1;
        cfg_thr = v;
        @(negedge clk);
        cfg_we = 1'b0;
        m_thr  = int'(v);
    endtask

    // Result presented while holding
    task automatic check_hold(input string tag, input int ea, input int eb, input int ec, input int elen);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
        chk({tag, "_out_a"},     32'(out_a), 32'(ea));
        chk({tag, "_out_b"},     32'(out_b), 32'(eb));
        chk({tag, "_out_c"},     32'(out_c), 32'(ec));
        chk({tag, "_out_len"},   32'(out_len), 32'(elen));
`ifdef TNN_ACC_SAT_FLAG_EN
        chk({tag, "_out_sat"},   32'(out_sat),
            32'((m_a >= CNT_LIM) || (m_b >= CNT_LIM) || (m_n >= LEN_LIM)));
`endif
    endtask

    task automatic check_model(input string tag);
        check_hold(tag, clip(m_a, CNT_LIM), clip(m_b, CNT_LIM), m_c, clip(m_n, LEN_LIM));
    endtask

    // Consume the result; the block must be ready again on the following cycle
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"},  32'(in_ready), 32'd1);
`ifdef TNN_ACC_SAT_FLAG_EN
        chk({tag, "_post_out_sat"},   32'(out_sat), 32'd0);
`endif
        m_a = 0;
        m_b = 0;
        m_n = 0;
    endtask

    task automatic rand_frame(input int len, input string tag);
        int stall;
        logic [CNT_W-1:0] v;
        for (int i = 0; i < len; i++) send_beat(4'($urandom), 4'($urandom), (i == len - 1));
        check_model(tag);
        stall = int'($urandom_range(0, 3));
        for (int i = 0; i < stall; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = CNT_W'($urandom);
                write_thr(v);
            end else begin
                @(negedge clk);
            end
            chk({tag, "_stall_out_c"}, 32'(out_c), 32'(m_c));
        end
        handshake(tag);
    endtask

    initial begin
        int ea;
        int ec;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_x      = 4'($urandom);
            in_w      = 4'($urandom);
            in_last   = 1'($urandom);
            cfg_we    = 1'($urandom);
            cfg_thr   = CNT_W'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_out_a",     32'(out_a), 32'd0);
        chk("rst_out_b",     32'(out_b), 32'd0);
        chk("rst_out_c",     32'(out_c), 32'd0);
        chk("rst_out_len",   32'(out_len), 32'd0);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Three-beat frame: lane0 +1,+1,-1 ; lane1 +1,0,+1 ; thr 5
        write_thr(3'd5);
        send_beat(4'b1010, 4'b1010, 1'b0);
        send_beat(4'b0011, 4'b1111, 1'b0);
        chk("f3_mid_out_valid", 32'(out_valid), 32'd0);
        send_beat(4'b1110, 4'b1111, 1'b1);
        check_hold("f3", 2, 2, 5, 3);
        handshake("f3");

        // Ten beats, lane0 always +1, lane1 always 0
        for (int i = 0; i < 10; i++) send_beat(4'b0010, 4'b0010, (i == 9));
        check_hold("sat10", 7, 0, 5, 10);
        handshake("sat10");

        // Backpressure with input offered and a threshold write while holding
        send_beat(4'($urandom), 4'($urandom), 1'b0);
        send_beat(4'($urandom), 4'($urandom), 1'b1);
        ea = clip(m_a, CNT_LIM);
        ec = m_c;
        check_model("bp");
        in_valid = 1'b1;
        in_x     = 4'b1010;
        in_w     = 4'b1010;
        cfg_we   = 1'b1;
        cfg_thr  = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready), 32'd0);
            chk("bp_out_a",     32'(out_a), 32'(ea));
            chk("bp_out_c",     32'(out_c), 32'(ec));
        end
        m_thr = 2;
        handshake("bp");

        // Single-beat frame picks up the threshold written during backpressure
        send_beat(4'b1110, 4'b1110, 1'b1);
        check_hold("single", 1, 1, 2, 1);
        handshake("single");
        rand_frame(3, "b2b");

        // Threshold write coinciding with the last-beat accept is not seen by that frame
        send_beat(4'($urandom), 4'($urandom), 1'b0);
        cfg_we  = 1'b1;
        cfg_thr = 3'd6;
        send_beat(4'($urandom), 4'($urandom), 1'b1);
        check_hold("wlast", clip(m_a, CNT_LIM), clip(m_b, CNT_LIM), 2, 2);
        handshake("wlast");
        send_beat(4'b0000, 4'b0000, 1'b1);
        check_hold("zero", 0, 0, 6, 1);
        handshake("zero");

        // Reset in the middle of a frame
        send_beat(4'b1010, 4'b1010, 1'b0);
        send_beat(4'b1010, 4'b1010, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = 0;
        m_b = 0;
        m_n = 0;
        m_thr = 0;
        @(negedge clk);
        chk("midrst_rel_out_valid", 32'(out_valid), 32'd0);
        send_beat(4'b1111, 4'b1111, 1'b1);
        check_hold("midrst_next", 1, 1, 0, 1);
        handshake("midrst_next");

        // Random frames against the model
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 1) == 1) write_thr(CNT_W'($urandom));
            rand_frame(int'($urandom_range(1, 14)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tnn_dual_popcount_accum.md
Name: tnn_dual_popcount_accum

Overview:
- Sequential upstream stage for the 3-bit adder/threshold comparator neuron cell, which evaluates f(a, b, c) with a and b as partial popcounts and c as the threshold.
- Consumes a framed stream of ternary activation/weight pairs on two lanes per beat.
- Accumulates one saturating positive-match popcount per lane and snapshots the programmed threshold at frame end.
- Presents {a, b, c} to the comparator with a valid/ready handshake.

Parameters:
- CNT_W, 3, width of each lane count and of the threshold; matches the comparator operand width.
- LEN_W, 8, width of the frame beat counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_x  in  4  activations; [1:0] lane0, [3:2] lane1; ternary code {nz, sign}
- in_w  in  4  weights; same packing and code as in_x
- in_last  in  1  final beat of the frame
- cfg_we  in  1  threshold write strobe
- cfg_thr  in  CNT_W  threshold value
- out_valid  out  1  result valid
- out_ready  in  1  comparator accepts the result
- out_a  out  CNT_W  lane0 popcount (comparator input_a)
- out_b  out  CNT_W  lane1 popcount (comparator input_b)
- out_c  out  CNT_W  threshold snapshot (comparator input_c)
- out_len  out  LEN_W  number of beats in the frame, saturating

Behaviour:
- Reset is asynchronous and active-low.
  - State returns to IDLE.
  - Lane counts, beat count, thr_reg, out_a, out_b, out_c and out_len all clear to 0.
  - out_valid=0, in_ready=0 while rst_n=0.
- Ternary code: 10 means +1, 11 means -1; 00 and 01 both mean 0.
- Per-lane product is +1 when both operands are nonzero and their signs are equal. The lane increments only on +1 products; -1 and 0 products do not change the count.
- Lane counts saturate at 2^CNT_W-1 (7). No wrap.
- Beat count saturates at 2^LEN_W-1.
- Accept = in_valid & in_ready.
- State machine:
  - IDLE: in_ready=1, out_valid=0.
    - Accept without in_last: update counts and move to ACCUM.
    - Accept with in_last (single-beat frame): go directly to HOLD.
  - ACCUM: in_ready=1, out_valid=0.
    - Each accept updates counts.
    - Accept with in_last moves to HOLD.
  - HOLD: in_ready=0, out_valid=1.
    - Outputs hold the final counts including the last beat.
    - out_c = thr_reg value as of the cycle the last beat was accepted.
    - out_valid & out_ready: clear counts and return to IDLE on the next edge. in_ready stays 0 during that handshake cycle.
- Latency: out_valid asserts on the cycle after the in_last beat is accepted.
- Outputs are registered and stable while out_valid=1 and out_ready=0.
- in_valid with in_ready=0 is ignored; the upstream source holds the beat.
- Threshold register:
  - cfg_we loads thr_reg on the next edge, in any state.
  - A write in the same cycle as the last-beat accept is not seen by that frame; the snapshot takes the old value.
  - A write during HOLD does not alter out_c.
- Frames have no minimum length. A frame whose products are all 0 yields a=b=0.
- Reset asserted mid-frame or in HOLD aborts the frame immediately. No partial result is emitted.

Optional Feature:
- Macro TNN_ACC_SAT_FLAG_EN.
- Defined:
  - Adds output port out_sat (1 bit, registered, reset 0).
  - out_sat is set in HOLD if either lane count or the beat count saturated during the frame. This includes increments attempted while already at maximum.
  - out_sat is valid with out_valid and cleared on return to IDLE.
- Undefined:
  - Port is absent.
  - Saturation is still applied silently.

Test Plan:
- Reset: rst_n=0 for 3 cycles with random inputs -> all outputs 0, in_ready=0. Release -> in_ready=1 next cycle.
- 3-beat frame, lane0 products +1,+1,-1 and lane1 products +1,0,+1, thr=5 -> out_a=2, out_b=2, out_c=5, out_len=3, out_valid asserted 1 cycle after the last accept.
- 10-beat frame with all lane0 products +1 and lane1 all 0 -> out_a=7 (saturated), out_b=0, out_len=10. With macro: out_sat=1.
- Backpressure: hold out_ready=0 for 4 cycles in HOLD while in_valid=1 and cfg_we writes 2 -> outputs stable, in_ready=0, out_c unchanged. Next frame snapshots 2.
- Single-beat frame (in_last on the first beat) with lane0 x=10, w=10 and lane1 x=11, w=11 -> out_a=1, out_b=1, out_len=1. Back-to-back next frame accepted starting the cycle after the handshake.
- Mid-frame reset after 2 beats -> no out_valid. Next frame counts start from 0.
